// File: rtl/mc_control_fsm_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mc_ctrl_pkg : states, decode constants and control encodings      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JR       = 4'd12,
    S_TRAP     = 4'd13
  } state_e;

  typedef enum logic [2:0] {
    CLS_R, CLS_JR, CLS_LOAD, CLS_STORE, CLS_IMM, CLS_BR, CLS_JMP, CLS_ILLEGAL
  } insn_class_e;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_SLTI    = 6'b001010;
  localparam logic [5:0] OP_SLTIU   = 6'b001011;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LB      = 6'b100000;
  localparam logic [5:0] OP_LH      = 6'b100001;
  localparam logic [5:0] OP_LWL     = 6'b100010;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_LBU     = 6'b100100;
  localparam logic [5:0] OP_LHU     = 6'b100101;
  localparam logic [5:0] OP_LWR     = 6'b100110;
  localparam logic [5:0] OP_SB      = 6'b101000;
  localparam logic [5:0] OP_SH      = 6'b101001;
  localparam logic [5:0] OP_SWL     = 6'b101010;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_SWR     = 6'b101110;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;
  localparam logic [5:0] FN_MOVZ = 6'b001010;
  localparam logic [5:0] FN_MOVN = 6'b001011;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [4:0] RT_BLTZ = 5'b00000;
  localparam logic [4:0] RT_BGEZ = 5'b00001;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_SUB    = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;
  localparam logic [1:0] ALU_OP_OPCODE = 2'b11;

  localparam logic [1:0] ALU_B_RT       = 2'b00;
  localparam logic [1:0] ALU_B_FOUR     = 2'b01;
  localparam logic [1:0] ALU_B_SIMM     = 2'b10;
  localparam logic [1:0] ALU_B_SIMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_RS     = 2'b11;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       insn_done;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/mc_control_fsm_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mc_control_fsm_if : IR fields / memory ack in, datapath controls  |
// | out. illegal_insn exists only with MC_CTRL_ILLEGAL_TRAP_EN.  R1.0 |
// +------------------------------------------------------------------+
interface mc_control_fsm_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt_field;
  logic       branch_cond;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       iord;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_source;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       insn_done;
  logic [3:0] state;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic       illegal_insn;
`endif

  modport master (
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    output illegal_insn,
`endif
    input  opcode, funct, rt_field, branch_cond, mem_ready,
    output mem_req, mem_write, iord, ir_write, pc_write, pc_source,
    output alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg,
    output insn_done, state
  );

  modport slave (
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    input  illegal_insn,
`endif
    output opcode, funct, rt_field, branch_cond, mem_ready,
    input  mem_req, mem_write, iord, ir_write, pc_write, pc_source,
    input  alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg,
    input  insn_done, state
  );
endinterface
`default_nettype wire

// File: rtl/mc_control_fsm_insn_class.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mc_insn_class : combinational opcode/funct/rt -> instruction class|
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module mc_insn_class
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  rt_field,
  output insn_class_e insn_class,
  output logic        is_link
);

  always_comb begin
    insn_class = CLS_ILLEGAL;
    is_link    = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU,
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV, FN_MOVN, FN_MOVZ:
            insn_class = CLS_R;
          FN_JR:   insn_class = CLS_JR;
          FN_JALR: begin
            insn_class = CLS_JR;
            is_link    = 1'b1;
          end
          default: insn_class = CLS_ILLEGAL;
        endcase
      end
      OP_REGIMM: begin
        if (rt_field == RT_BLTZ || rt_field == RT_BGEZ) insn_class = CLS_BR;
      end
      OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LWL, OP_LWR:
        insn_class = CLS_LOAD;
      OP_SW, OP_SB, OP_SH, OP_SWL, OP_SWR:
        insn_class = CLS_STORE;
      OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU, OP_LUI:
        insn_class = CLS_IMM;
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
        insn_class = CLS_BR;
      OP_J:    insn_class = CLS_JMP;
      OP_JAL: begin
        insn_class = CLS_JMP;
        is_link    = 1'b1;
      end
      default: insn_class = CLS_ILLEGAL;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mc_control_fsm : multi-cycle MIPS control sequencer. Optional     |
// | illegal-instruction trap via MC_CTRL_ILLEGAL_TRAP_EN.  Rev 1.0    |
// +------------------------------------------------------------------+
module mc_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  mc_control_fsm_if.master     bus
);

  insn_class_e insn_class;
  logic        is_link;
  state_e      state_q;
  state_e      state_d;
  ctrl_t       ctl;

  mc_insn_class u_insn_class (
    .opcode     (bus.opcode),
    .funct      (bus.funct),
    .rt_field   (bus.rt_field),
    .insn_class (insn_class),
    .is_link    (is_link)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (insn_class)
          CLS_LOAD, CLS_STORE: state_d = S_MEM_ADDR;
          CLS_R:               state_d = S_R_EXEC;
          CLS_IMM:             state_d = S_I_EXEC;
          CLS_BR:              state_d = S_BRANCH;
          CLS_JMP:             state_d = S_JUMP;
          CLS_JR:              state_d = S_JR;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          default:             state_d = S_TRAP;
`else
          default:             state_d = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR: state_d = (insn_class == CLS_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (bus.mem_ready) state_d = S_MEM_WB;
      S_MEM_WR:   if (bus.mem_ready) state_d = S_FETCH;
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JR:
        state_d = S_FETCH;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // Reset overrides every control so an in-flight access is abandoned at once.
  always_comb begin
    ctl = '0;
    case (state_q)
      S_FETCH: begin
        ctl.mem_req   = 1'b1;
        ctl.alu_src_b = ALU_B_FOUR;
        ctl.alu_op    = ALU_OP_ADD;
        ctl.pc_source = PC_SRC_ALU;
        ctl.ir_write  = bus.mem_ready;
        ctl.pc_write  = bus.mem_ready;
      end
      S_DECODE: begin
        ctl.alu_src_b = ALU_B_SIMM_SH2;
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
        ctl.insn_done = (insn_class == CLS_ILLEGAL);
`endif
      end
      S_MEM_ADDR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = ALU_B_SIMM;
      end
      S_MEM_RD: begin
        ctl.mem_req = 1'b1;
        ctl.iord    = 1'b1;
      end
      S_MEM_WR: begin
        ctl.mem_req   = 1'b1;
        ctl.iord      = 1'b1;
        ctl.mem_write = 1'b1;
        ctl.insn_done = bus.mem_ready;
      end
      S_MEM_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = REG_DST_RT;
        ctl.mem_to_reg = WB_MDR;
        ctl.insn_done  = 1'b1;
      end
      S_R_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = ALU_B_RT;
        ctl.alu_op    = ALU_OP_FUNCT;
      end
      S_R_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = REG_DST_RD;
        ctl.mem_to_reg = WB_ALUOUT;
        ctl.insn_done  = 1'b1;
      end
      S_I_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = ALU_B_SIMM;
        ctl.alu_op    = ALU_OP_OPCODE;
      end
      S_I_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = REG_DST_RT;
        ctl.mem_to_reg = WB_ALUOUT;
        ctl.insn_done  = 1'b1;
      end
      S_BRANCH: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = ALU_B_RT;
        ctl.alu_op    = ALU_OP_SUB;
        ctl.pc_source = PC_SRC_ALUOUT;
        ctl.pc_write  = bus.branch_cond;
        ctl.insn_done = 1'b1;
      end
      S_JUMP: begin
        ctl.pc_write   = 1'b1;
        ctl.pc_source  = PC_SRC_JUMP;
        ctl.reg_write  = is_link;
        ctl.reg_dst    = is_link ? REG_DST_RA : REG_DST_RT;
        ctl.mem_to_reg = is_link ? WB_PC : WB_ALUOUT;
        ctl.insn_done  = 1'b1;
      end
      S_JR: begin
        ctl.pc_write   = 1'b1;
        ctl.pc_source  = PC_SRC_RS;
        ctl.reg_write  = is_link;
        ctl.reg_dst    = is_link ? REG_DST_RD : REG_DST_RT;
        ctl.mem_to_reg = is_link ? WB_PC : WB_ALUOUT;
        ctl.insn_done  = 1'b1;
      end
      default: ctl = '0;
    endcase
    if (rst) ctl = '0;
  end

  assign bus.mem_req    = ctl.mem_req;
  assign bus.mem_write  = ctl.mem_write;
  assign bus.iord       = ctl.iord;
  assign bus.ir_write   = ctl.ir_write;
  assign bus.pc_write   = ctl.pc_write;
  assign bus.pc_source  = ctl.pc_source;
  assign bus.alu_src_a  = ctl.alu_src_a;
  assign bus.alu_src_b  = ctl.alu_src_b;
  assign bus.alu_op     = ctl.alu_op;
  assign bus.reg_write  = ctl.reg_write;
  assign bus.reg_dst    = ctl.reg_dst;
  assign bus.mem_to_reg = ctl.mem_to_reg;
  assign bus.insn_done  = ctl.insn_done;
  assign bus.state      = rst ? 4'd0 : state_q;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign bus.illegal_insn = !rst && (state_q == S_TRAP);
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mc_control_fsm : vector table plus multi-cycle corner sequences|
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_mc_control_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  mc_control_fsm_if bus ();

  mc_control_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rt;
    logic        bc;
    int          cycles;
    logic [3:0]  last_state;
    logic [16:0] last_out;
  } vec_t;

  vec_t        vt [14];
  logic [3:0]  seq_st  [8];
  bit          seq_mr  [8];
  logic [16:0] seq_out [8];

  function automatic logic [16:0] outs();
    return {bus.mem_req, bus.mem_write, bus.iord, bus.ir_write, bus.pc_write,
            bus.pc_source, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
            bus.reg_write, bus.reg_dst, bus.mem_to_reg};
  endfunction

  function automatic logic [16:0] mk(input logic mreq, input logic mw, input logic io,
                                     input logic irw, input logic pcw, input logic [1:0] pcs,
                                     input logic asa, input logic [1:0] asb, input logic [1:0] aop,
                                     input logic rw, input logic [1:0] rd, input logic [1:0] m2r);
    return {mreq, mw, io, irw, pcw, pcs, asa, asb, aop, rw, rd, m2r};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_insn(input logic [5:0] op, input logic [5:0] fn,
                          input logic [4:0] rt, input logic bc);
    bus.opcode      = op;
    bus.funct       = fn;
    bus.rt_field    = rt;
    bus.branch_cond = bc;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Entered 1 time unit after an edge with the FSM in FETCH.
  task automatic run_vec(input int id);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    set_insn(vt[id].op, vt[id].fn, vt[id].rt, vt[id].bc);
    bus.mem_ready = 1'b1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk($sformatf("v%0d_fetch_state", id), 32'(bus.state), 32'd0);
        chk($sformatf("v%0d_fetch_out", id), 32'(outs()),
            32'(mk(1,0,0,1,1,2'b00,0,2'b01,2'b00,0,2'b00,2'b00)));
      end
      if (n == 2)
        chk($sformatf("v%0d_decode_out", id), 32'(outs()),
            32'(mk(0,0,0,0,0,2'b00,0,2'b11,2'b00,0,2'b00,2'b00)));
      if (bus.insn_done) begin
        done = 1'b1;
        chk($sformatf("v%0d_cycles", id), 32'(n), 32'(vt[id].cycles));
        chk($sformatf("v%0d_last_state", id), 32'(bus.state), 32'(vt[id].last_state));
        chk($sformatf("v%0d_last_out", id), 32'(outs()), 32'(vt[id].last_out));
      end
      next_cycle();
    end
    if (!done) chk($sformatf("v%0d_insn_done_timeout", id), 32'd0, 32'd1);
  endtask

  // Runs len cycles from FETCH, mem_ready per cycle from seq_mr, checking
  // the state trace and that insn_done pulses only in the final cycle.
  task automatic run_seq(input string name, input int len);
    for (int i = 0; i < len; i++) begin
      bus.mem_ready = seq_mr[i];
      @(negedge clk);
      chk($sformatf("%s_state_c%0d", name, i + 1), 32'(bus.state), 32'(seq_st[i]));
      chk($sformatf("%s_done_c%0d", name, i + 1), 32'(bus.insn_done), 32'(i == len - 1));
      seq_out[i] = outs();
      next_cycle();
    end
  endtask

  initial begin
    vt[0]  = '{6'h00, 6'h21, 5'd0, 1'b0, 4, 4'd7,  mk(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,2'b01,2'b00)};
    vt[1]  = '{6'h00, 6'h00, 5'd0, 1'b0, 4, 4'd7,  mk(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,2'b01,2'b00)};
    vt[2]  = '{6'h2B, 6'h00, 5'd0, 1'b0, 4, 4'd5,  mk(1,1,1,0,0,2'b00,0,2'b00,2'b00,0,2'b00,2'b00)};
    vt[3]  = '{6'h23, 6'h00, 5'd0, 1'b0, 5, 4'd4,  mk(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,2'b00,2'b01)};
    vt[4]  = '{6'h09, 6'h00, 5'd0, 1'b0, 4, 4'd9,  mk(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,2'b00,2'b00)};
    vt[5]  = '{6'h0F, 6'h00, 5'd0, 1'b0, 4, 4'd9,  mk(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,2'b00,2'b00)};
    vt[6]  = '{6'h04, 6'h00, 5'd0, 1'b0, 3, 4'd10, mk(0,0,0,0,0,2'b01,1,2'b00,2'b01,0,2'b00,2'b00)};
    vt[7]  = '{6'h04, 6'h00, 5'd0, 1'b1, 3, 4'd10, mk(0,0,0,0,1,2'b01,1,2'b00,2'b01,0,2'b00,2'b00)};
    vt[8]  = '{6'h02, 6'h00, 5'd0, 1'b0, 3, 4'd11, mk(0,0,0,0,1,2'b10,0,2'b00,2'b00,0,2'b00,2'b00)};
    vt[9]  = '{6'h03, 6'h00, 5'd0, 1'b0, 3, 4'd11, mk(0,0,0,0,1,2'b10,0,2'b00,2'b00,1,2'b10,2'b10)};
    vt[10] = '{6'h00, 6'h08, 5'd0, 1'b0, 3, 4'd12, mk(0,0,0,0,1,2'b11,0,2'b00,2'b00,0,2'b00,2'b00)};
    vt[11] = '{6'h00, 6'h09, 5'd0, 1'b0, 3, 4'd12, mk(0,0,0,0,1,2'b11,0,2'b00,2'b00,1,2'b01,2'b10)};
    vt[12] = '{6'h01, 6'h00, 5'd1, 1'b1, 3, 4'd10, mk(0,0,0,0,1,2'b01,1,2'b00,2'b01,0,2'b00,2'b00)};
    vt[13] = '{6'h20, 6'h00, 5'd0, 1'b0, 5, 4'd4,  mk(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,2'b00,2'b01)};

    set_insn(6'h00, 6'h21, 5'd0, 1'b0);
    bus.mem_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("reset_outs", 32'(outs()), 32'd0);
    chk("reset_state", 32'(bus.state), 32'd0);
    chk("reset_done", 32'(bus.insn_done), 32'd0);
    next_cycle();
    next_cycle();
    rst = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(i);

    // lw with two wait cycles in MEM_RD
    set_insn(6'h23, 6'h00, 5'd0, 1'b0);
    seq_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    seq_mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    run_seq("lw_wait", 7);
    chk("lw_memaddr_out", 32'(seq_out[2]), 32'(mk(0,0,0,0,0,2'b00,1,2'b10,2'b00,0,2'b00,2'b00)));
    for (int i = 3; i < 6; i++)
      chk($sformatf("lw_memrd_out_c%0d", i + 1), 32'(seq_out[i]),
          32'(mk(1,0,1,0,0,2'b00,0,2'b00,2'b00,0,2'b00,2'b00)));
    chk("lw_memwb_out", 32'(seq_out[6]), 32'(mk(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,2'b00,2'b01)));

    // sw with one wait cycle in MEM_WR: done only once mem_ready arrives
    set_insn(6'h2B, 6'h00, 5'd0, 1'b0);
    seq_st = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd0, 4'd0, 4'd0};
    seq_mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    run_seq("sw_wait", 5);

    // fetch wait: no IR/PC load until mem_ready; mem_ready in DECODE is ignored
    set_insn(6'h00, 6'h21, 5'd0, 1'b0);
    seq_st = '{4'd0, 4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd0, 4'd0};
    seq_mr = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    run_seq("fetch_wait", 5);
    chk("fetch_wait_no_load", 32'(seq_out[0]), 32'(mk(1,0,0,0,0,2'b00,0,2'b01,2'b00,0,2'b00,2'b00)));

    // rst during a fetch wait
    bus.mem_ready = 1'b0;
    next_cycle();
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("rst_fetch_outs", 32'(outs()), 32'd0);
    chk("rst_fetch_done", 32'(bus.insn_done), 32'd0);
    next_cycle();
    rst = 1'b0;
    run_vec(0);

    // rst during a MEM_RD wait abandons the load
    set_insn(6'h23, 6'h00, 5'd0, 1'b0);
    seq_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0};
    seq_mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = seq_mr[i];
      @(negedge clk);
      chk($sformatf("rst_lw_state_c%0d", i + 1), 32'(bus.state), 32'(seq_st[i]));
      next_cycle();
    end
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("rst_memrd_outs", 32'(outs()), 32'd0);
    chk("rst_memrd_state", 32'(bus.state), 32'd0);
    next_cycle();
    rst = 1'b0;
    run_vec(3);

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    set_insn(6'h3F, 6'h00, 5'd0, 1'b0);
    bus.mem_ready = 1'b1;
    seq_st = '{4'd0, 4'd1, 4'd13, 4'd13, 4'd13, 4'd13, 4'd13, 4'd13};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("trap_state_c%0d", i + 1), 32'(bus.state), 32'((i < 2) ? seq_st[i] : 4'd13));
      chk($sformatf("trap_done_c%0d", i + 1), 32'(bus.insn_done), 32'd0);
      chk($sformatf("trap_flag_c%0d", i + 1), 32'(bus.illegal_insn), 32'(i >= 2));
      if (i >= 2) chk($sformatf("trap_outs_c%0d", i + 1), 32'(outs()), 32'd0);
      next_cycle();
    end
    rst = 1'b1;
    @(negedge clk);
    chk("trap_rst_flag", 32'(bus.illegal_insn), 32'd0);
    next_cycle();
    rst = 1'b0;
    run_vec(0);
`else
    set_insn(6'h3F, 6'h00, 5'd0, 1'b0);
    seq_st = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    seq_mr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    run_seq("illegal_nop", 2);
    run_vec(0);
    set_insn(6'h01, 6'h00, 5'd2, 1'b1);
    run_seq("regimm_nop", 2);
    run_vec(6);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
